// File: rtl/ast_ctrl.sv
// Burst pulse controller: fires a one-cycle command to the pulse sender a programmed
// number of times (or continuously) at a microsecond-timed interval.
//
// state  | meaning
// S_IDLE | waiting for start; shadows and stat_cnt hold last burst
// S_FIRE | one cycle: bump pulse count, clear us counter
// S_WAIT | count us strobes until eff_period reached
// S_NEXT | decide: another fire or end of burst
// S_DONE | one cycle: stat_done strobe
module ast_ctrl (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic [7:0]  cmd_start,
  input  logic [7:0]  cmd_stop,
  input  logic [15:0] cfg_period,
  input  logic [7:0]  cfg_num,
  input  logic [7:0]  cfg_width,
  output logic [7:0]  cmd_ast,
  output logic        stat_busy,
  output logic [7:0]  stat_cnt,
  output logic        stat_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FIRE = 3'd1,
    S_WAIT = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] sh_period;
  logic [7:0]  sh_num;
  logic [7:0]  sh_width;
  logic [15:0] us_cnt;
  logic        stop_pend;
  logic [15:0] width_min;
  logic [15:0] eff_period;
  logic        start_ok;
  logic        stop_req;

  assign start_ok   = (cmd_start == 8'h01) && (cmd_stop != 8'h01);
  assign stop_req   = (cmd_stop == 8'h01);
  // interval never shorter than the sender's pulse plus its return-to-idle margin
  assign width_min  = {8'h00, sh_width} + 16'd2;
  assign eff_period = (sh_period > width_min) ? sh_period : width_min;

  assign stat_busy  = (state != S_IDLE);
  assign stat_done  = (state == S_DONE);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_FIRE;
      S_FIRE: state_nxt = S_WAIT;
      S_WAIT: if (us_cnt == eff_period) state_nxt = S_NEXT;
      S_NEXT: begin
        if (stop_pend || ((sh_num != 8'h00) && (stat_cnt == sh_num))) state_nxt = S_DONE;
        else                                                          state_nxt = S_FIRE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sh_period <= 16'h0000;
      sh_num    <= 8'h00;
      sh_width  <= 8'h00;
      us_cnt    <= 16'h0000;
      stop_pend <= 1'b0;
      stat_cnt  <= 8'h00;
      cmd_ast   <= 8'h00;
    end else begin
      if (state == S_IDLE) begin
        if (start_ok) begin
          sh_period <= cfg_period;
          sh_num    <= cfg_num;
          sh_width  <= cfg_width;
          stat_cnt  <= 8'h00;
          stop_pend <= 1'b0;
        end
      end else if (stop_req) begin
        stop_pend <= 1'b1;
      end

      if (state == S_FIRE) begin
        stat_cnt <= stat_cnt + 8'h01;
        us_cnt   <= 16'h0000;
      end else if ((state == S_WAIT) && pluse_us) begin
        us_cnt <= us_cnt + 16'h0001;
      end

      cmd_ast <= (state == S_FIRE) ? 8'h01 : 8'h00;
    end
  end

endmodule

// File: tb/tb_ast_ctrl.sv
// Directed bench for ast_ctrl: bursts, period clamp, stop, ignored commands,
// config isolation and mid-burst reset, with hand-computed expectations.
module tb_ast_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        pluse_us = 1'b0;
  logic [7:0]  cmd_start = 8'h00;
  logic [7:0]  cmd_stop = 8'h00;
  logic [15:0] cfg_period = 16'd0;
  logic [7:0]  cfg_num = 8'd0;
  logic [7:0]  cfg_width = 8'd0;
  logic [7:0]  cmd_ast;
  logic        stat_busy;
  logic [7:0]  stat_cnt;
  logic        stat_done;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_fire = 0;
  int n_done = 0;
  int fire_t[16];

  ast_ctrl dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .pluse_us  (pluse_us),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cfg_period(cfg_period),
    .cfg_num   (cfg_num),
    .cfg_width (cfg_width),
    .cmd_ast   (cmd_ast),
    .stat_busy (stat_busy),
    .stat_cnt  (stat_cnt),
    .stat_done (stat_done)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  // one-cycle microsecond strobe every 10 clocks
  initial begin
    forever begin
      repeat (9) @(posedge clk_sys);
      #1 pluse_us = 1'b1;
      @(posedge clk_sys);
      #1 pluse_us = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk_sys) begin
    if (cmd_ast !== 8'h00) begin
      chk("ast_val", {24'h0, cmd_ast}, 32'd1);
      if (n_fire < 16) fire_t[n_fire] = cyc;
      n_fire++;
    end
    if (stat_done === 1'b1) n_done++;
  end

  task automatic set_cfg(input int per, input int num, input int wid);
    cfg_period = per[15:0];
    cfg_num    = num[7:0];
    cfg_width  = wid[7:0];
  endtask

  task automatic do_start();
    @(posedge clk_sys);
    #1 cmd_start = 8'h01;
    @(posedge clk_sys);
    #1 cmd_start = 8'h00;
  endtask

  task automatic do_stop();
    @(posedge clk_sys);
    #1 cmd_stop = 8'h01;
    @(posedge clk_sys);
    #1 cmd_stop = 8'h00;
  endtask

  task automatic clear_log();
    n_fire = 0;
    n_done = 0;
  endtask

  task automatic wait_fires(input int n, input int budget);
    int i;
    i = 0;
    while (n_fire < n && i < budget) begin
      @(negedge clk_sys);
      i++;
    end
    chk("fire_timeout", {31'h0, n_fire >= n}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (stat_done !== 1'b1 && i < budget) begin
      @(negedge clk_sys);
      i++;
    end
    chk("done_timeout", {31'h0, i < budget}, 32'd1);
    repeat (3) @(negedge clk_sys);
  endtask

  // first interval depends on the start phase against the strobe: 10*eff-9 .. 10*eff+3 clocks
  function automatic logic [31:0] ivl_near(input int d, input int eff);
    return {31'h0, (d >= 10*eff - 9) && (d <= 10*eff + 3)};
  endfunction

  initial begin
    bit busy_seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_ast",  {24'h0, cmd_ast}, 32'd0);
    chk("rst_busy", {31'h0, stat_busy}, 32'd0);
    chk("rst_cnt",  {24'h0, stat_cnt}, 32'd0);
    chk("rst_done", {31'h0, stat_done}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    // basic burst: eff=10 us
    set_cfg(10, 3, 4);
    clear_log();
    do_start();
    wait_done(2000);
    chk("b_fires", n_fire, 32'd3);
    chk("b_ivl0",  ivl_near(fire_t[1] - fire_t[0], 10), 32'd1);
    chk("b_ivl1",  fire_t[2] - fire_t[1], 32'd100);
    chk("b_done",  n_done, 32'd1);
    chk("b_cnt",   {24'h0, stat_cnt}, 32'd3);
    chk("b_busy",  {31'h0, stat_busy}, 32'd0);
    repeat (50) @(negedge clk_sys);
    chk("b_hold",  {24'h0, stat_cnt}, 32'd3);

    // period clamped to width+2 = 10 us
    set_cfg(2, 2, 8);
    clear_log();
    do_start();
    wait_done(2000);
    chk("c_fires", n_fire, 32'd2);
    chk("c_ivl0",  ivl_near(fire_t[1] - fire_t[0], 10), 32'd1);
    chk("c_cnt",   {24'h0, stat_cnt}, 32'd2);

    // continuous, stopped during the wait after fire 4
    set_cfg(5, 0, 0);
    clear_log();
    do_start();
    wait_fires(4, 2000);
    repeat (5) @(negedge clk_sys);
    do_stop();
    wait_done(2000);
    chk("s_fires", n_fire, 32'd4);
    chk("s_ivl2",  fire_t[2] - fire_t[1], 32'd50);
    chk("s_ivl3",  fire_t[3] - fire_t[2], 32'd50);
    chk("s_done",  n_done, 32'd1);
    chk("s_cnt",   {24'h0, stat_cnt}, 32'd4);

    // simultaneous start+stop, then a non-1 start value: both no-ops
    set_cfg(10, 3, 4);
    clear_log();
    busy_seen = 1'b0;
    @(posedge clk_sys);
    #1 begin cmd_start = 8'h01; cmd_stop = 8'h01; end
    @(posedge clk_sys);
    #1 begin cmd_start = 8'h02; cmd_stop = 8'h00; end
    @(posedge clk_sys);
    #1 cmd_start = 8'h00;
    repeat (30) begin
      @(negedge clk_sys);
      busy_seen |= stat_busy;
    end
    chk("ss_fires", n_fire, 32'd0);
    chk("ss_busy",  {31'h0, busy_seen}, 32'd0);

    // start during a burst is ignored
    clear_log();
    do_start();
    wait_fires(1, 500);
    repeat (20) @(negedge clk_sys);
    do_start();
    wait_done(2000);
    chk("ig_fires", n_fire, 32'd3);
    chk("ig_cnt",   {24'h0, stat_cnt}, 32'd3);

    // config change mid-burst has no effect
    set_cfg(10, 3, 4);
    clear_log();
    do_start();
    wait_fires(1, 500);
    cfg_period = 16'd50;
    wait_done(3000);
    chk("cf_fires", n_fire, 32'd3);
    chk("cf_ivl1",  fire_t[2] - fire_t[1], 32'd100);

    // reset during S_WAIT
    set_cfg(10, 3, 4);
    clear_log();
    do_start();
    wait_fires(1, 500);
    repeat (30) @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    chk("mr_ast",  {24'h0, cmd_ast}, 32'd0);
    chk("mr_busy", {31'h0, stat_busy}, 32'd0);
    chk("mr_cnt",  {24'h0, stat_cnt}, 32'd0);
    chk("mr_done", {31'h0, stat_done}, 32'd0);
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (300) @(negedge clk_sys);
    chk("mr_quiet", n_fire, 32'd1);
    clear_log();
    do_start();
    wait_fires(1, 500);
    @(negedge clk_sys);
    chk("mr_cnt1",  {24'h0, stat_cnt}, 32'd1);
    wait_done(2000);
    chk("mr_fires", n_fire, 32'd3);
    chk("mr_cnt3",  {24'h0, stat_cnt}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ast_ctrl.md
AST_CTRL -- requirements
Module: ast_ctrl

Interface
REQ-001 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port pluse_us  input  1  one-clk_sys-wide strobe, once per microsecond.
REQ-004 SHALL have port cmd_start  input  8  start command; value 8'h1 = start, any other value = no-op.
REQ-005 SHALL have port cmd_stop  input  8  stop command; value 8'h1 = stop request, any other value = no-op.
REQ-006 SHALL have port cfg_period  input  16  pulse-to-pulse interval in microseconds.
REQ-007 SHALL have port cfg_num  input  8  number of pulses per burst; 0 = continuous.
REQ-008 SHALL have port cfg_width  input  8  pulse width in microseconds, as programmed into the pulse sender.
REQ-009 SHALL have port cmd_ast  output  8  fire command to the pulse sender; 8'h1 = fire, else 8'h0.
REQ-010 SHALL have port stat_busy  output  1  high while a burst is in progress.
REQ-011 SHALL have port stat_cnt  output  8  pulses fired in the current or last burst.
REQ-012 SHALL have port stat_done  output  1  one-cycle pulse at burst end.

Function
REQ-013 SHALL implement FSM states S_IDLE, S_FIRE, S_WAIT, S_NEXT, S_DONE.
REQ-014 S_IDLE: on cmd_start==8'h1 with cmd_stop!=8'h1, SHALL do all of the following:
- latch cfg_period, cfg_num and cfg_width into shadow registers;
- clear stat_cnt and the stop-pending flag;
- go to S_FIRE.
REQ-015 S_IDLE with simultaneous start and stop SHALL remain in S_IDLE (stop wins).
REQ-016 S_FIRE SHALL last exactly one cycle, then go to S_WAIT.
- In that cycle: stat_cnt += 1 and the us counter is cleared.
REQ-017 cmd_ast SHALL be 8'h1 in exactly the cycle following each S_FIRE cycle (registered), and 8'h0 at all other times.
REQ-018 S_WAIT: the 16-bit us counter SHALL increment on each pluse_us. The FSM leaves for S_NEXT in the cycle the counter equals eff_period.
REQ-019 eff_period SHALL be max(shadow period, shadow width + 2), computed in 16 bits with width zero-extended. This guarantees the sender returns to idle before the next fire.
REQ-020 S_NEXT SHALL last one cycle:
- go to S_DONE if stop-pending, or if (shadow num != 0 and stat_cnt == shadow num);
- otherwise go to S_FIRE.
REQ-021 S_DONE SHALL last one cycle, assert stat_done in that cycle, then return to S_IDLE.
REQ-022 cmd_stop==8'h1 in any state other than S_IDLE SHALL set stop-pending; the current S_WAIT interval always completes (no mid-pulse abort).
REQ-023 cmd_start in any state other than S_IDLE SHALL be ignored.
REQ-024 Changes to cfg_* during a burst SHALL have no effect until the next start.
REQ-025 stat_cnt SHALL wrap 8'hFF->8'h00 in continuous mode. stat_cnt SHALL hold its value in S_IDLE after a burst.
REQ-026 stat_busy SHALL be high in every state except S_IDLE.
REQ-027 Illegal state encodings SHALL return to S_IDLE on the next clock.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously set:
- state = S_IDLE;
- cmd_ast = 8'h0, stat_busy = 0, stat_cnt = 8'h0, stat_done = 0;
- us counter, shadow registers and stop-pending cleared.
REQ-029 Reset asserted mid-burst SHALL abort the burst. No cmd_ast SHALL be issued until a new start after reset release.

Verification
REQ-030 Basic burst: period=10, num=3, width=4, pluse_us every 10 clk, start -> three one-cycle cmd_ast=8'h1 pulses 10 us apart, then stat_done once, stat_cnt=3, stat_busy low.
REQ-031 Period clamp: period=2, width=8, num=2 -> fires spaced 10 us apart.
REQ-032 Continuous plus stop: num=0, period=5; after the 4th fire assert stop in S_WAIT -> interval completes, no 5th fire, stat_done, stat_cnt=4.
REQ-033 Simultaneous start and stop in S_IDLE -> no cmd_ast, stat_busy stays 0. Start mid-burst -> ignored, count unchanged.
REQ-034 Config change mid-burst: change period 10->50 after the 1st fire -> remaining fires stay 10 us apart.
REQ-035 Reset mid-S_WAIT -> all outputs 0 immediately. A subsequent start gives a normal burst with stat_cnt counting from 1.
